// File: rtl/scs16_mem_pkg.sv
// scs16_mem_pkg: shared dmem constants, LSU FSM states and access encodings.
// No ports; imported by dmem_lsu_if, dmem_lane_align and dmem_lsu.
package scs16_mem_pkg;
    localparam int DMEM_WIDTH    = 28;
    localparam int DMEM_ADD_SIZE = 11;
    localparam int DMEM_ADDR_W   = DMEM_ADD_SIZE + 1;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} lsu_state_e;
    localparam logic [1:0] WEN_NONE = 2'b00;
    localparam logic [1:0] WEN_LO   = 2'b01;
    localparam logic [1:0] WEN_HI   = 2'b10;
    localparam logic [1:0] WEN_WORD = 2'b11;
    // Encoded so that the core's req_byte bit casts directly to the size.
    typedef enum logic {SIZE_WORD = 1'b0, SIZE_BYTE = 1'b1} size_e;
endpackage

// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: request/response channels between core and LSU plus the dmem port.
// Ports: none. Modports: slave = LSU view, master = core/dmem side (testbench).
interface dmem_lsu_if
    import scs16_mem_pkg::*;
#(
    parameter int WIDTH    = DMEM_WIDTH,
    parameter int ADD_SIZE = DMEM_ADD_SIZE,
    parameter int ADDR_W   = ADD_SIZE + 1
) ();
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic                req_byte;
    logic                req_sext;
    logic [ADDR_W-1:0]   req_addr;
    logic [15:0]         req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [15:0]         rsp_rdata;
    logic                rsp_err;
    logic                mem_cs;
    logic [1:0]          mem_wen;
    logic [ADD_SIZE-1:0] mem_address;
    logic [WIDTH-1:0]    mem_d;
    logic [WIDTH-1:0]    mem_q;
    modport slave (
        input  req_valid, req_we, req_byte, req_sext, req_addr, req_wdata, rsp_ready, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_cs, mem_wen, mem_address, mem_d
    );
    modport master (
        output req_valid, req_we, req_byte, req_sext, req_addr, req_wdata, rsp_ready, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_cs, mem_wen, mem_address, mem_d
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for stores and lane extraction for loads.
// Ports: i_a0 byte-address bit0, i_size access size, i_sext sign-extend byte loads,
//        i_wdata store data, i_q memory read data, o_wen lane enables, o_d steered
//        store data, o_rdata aligned/extended load data.
module dmem_lane_align
    import scs16_mem_pkg::*;
(
    input  logic        i_a0,
    input  size_e       i_size,
    input  logic        i_sext,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_q,
    output logic [1:0]  o_wen,
    output logic [15:0] o_d,
    output logic [15:0] o_rdata
);
    logic [7:0] w_lane;
    always_comb begin
        o_wen   = (i_size == SIZE_WORD) ? WEN_WORD : (i_a0 ? WEN_HI : WEN_LO);
        // Byte stores replicate the byte so either lane enable picks it up.
        o_d     = (i_size == SIZE_WORD) ? i_wdata : {2{i_wdata[7:0]}};
        w_lane  = i_a0 ? i_q[15:8] : i_q[7:0];
        o_rdata = (i_size == SIZE_WORD) ? i_q : {{8{i_sext & w_lane[7]}}, w_lane};
    end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator driving the dmem port for the scs16 core.
// Ports: clk, reset (async, active-high), bus (dmem_lsu_if.slave: req_* request
//        channel, rsp_* response channel, mem_* dmem port).
module dmem_lsu
    import scs16_mem_pkg::*;
#(
    parameter int WIDTH    = DMEM_WIDTH,
    parameter int ADD_SIZE = DMEM_ADD_SIZE,
    parameter int ADDR_W   = ADD_SIZE + 1
) (
    input  logic      clk,
    input  logic      reset,
    dmem_lsu_if.slave bus
);
    lsu_state_e          r_state, w_state_n;
    logic                r_cs, w_cs_n;
    logic [1:0]          r_wen, w_wen_n;
    logic [ADD_SIZE-1:0] r_address, w_address_n;
    logic [WIDTH-1:0]    r_d, w_d_n;
    logic                r_rsp_valid, w_rsp_valid_n;
    logic [15:0]         r_rdata, w_rdata_n;
    logic                r_err, w_err_n;
    logic                r_we, w_we_n;
    logic                r_a0, w_a0_n;
    size_e               r_size, w_size_n;
    logic                r_sext, w_sext_n;
    logic                w_a0;
    size_e               w_size;
    logic [1:0]          w_wen;
    logic [15:0]         w_d;
    logic [15:0]         w_rdata;
    logic                w_misaligned;
    logic                w_unused_q;

    // One aligner serves both directions: in IDLE it steers the incoming store,
    // afterwards it extracts from the latched request during CAPTURE.
    assign w_a0         = (r_state == IDLE) ? bus.req_addr[0] : r_a0;
    assign w_size       = (r_state == IDLE) ? size_e'(bus.req_byte) : r_size;
    assign w_misaligned = !bus.req_byte && bus.req_addr[0];
    assign w_unused_q   = ^bus.mem_q[WIDTH-1:16];

    dmem_lane_align u_align (
        .i_a0    (w_a0),
        .i_size  (w_size),
        .i_sext  (r_sext),
        .i_wdata (bus.req_wdata),
        .i_q     (bus.mem_q[15:0]),
        .o_wen   (w_wen),
        .o_d     (w_d),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cs        <= 1'b0;
            r_wen       <= WEN_NONE;
            r_address   <= '0;
            r_d         <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_a0        <= 1'b0;
            r_size      <= SIZE_WORD;
            r_sext      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cs        <= w_cs_n;
            r_wen       <= w_wen_n;
            r_address   <= w_address_n;
            r_d         <= w_d_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rdata     <= w_rdata_n;
            r_err       <= w_err_n;
            r_we        <= w_we_n;
            r_a0        <= w_a0_n;
            r_size      <= w_size_n;
            r_sext      <= w_sext_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cs_n        = 1'b0;
        w_wen_n       = WEN_NONE;
        w_address_n   = r_address;
        w_d_n         = r_d;
        w_rsp_valid_n = r_rsp_valid;
        w_rdata_n     = r_rdata;
        w_err_n       = r_err;
        w_we_n        = r_we;
        w_a0_n        = r_a0;
        w_size_n      = r_size;
        w_sext_n      = r_sext;
        case (r_state)
            IDLE: begin
                if (bus.req_valid && w_misaligned) begin
                    w_state_n     = RESP;
                    w_rsp_valid_n = 1'b1;
                    w_err_n       = 1'b1;
                    w_rdata_n     = '0;
                end else if (bus.req_valid) begin
                    w_state_n   = ACCESS;
                    w_cs_n      = 1'b1;
                    w_wen_n     = bus.req_we ? w_wen : WEN_NONE;
                    w_address_n = bus.req_addr[ADDR_W-1:1];
                    w_d_n       = bus.req_we ? {{(WIDTH-16){1'b0}}, w_d} : r_d;
                    w_we_n      = bus.req_we;
                    w_a0_n      = bus.req_addr[0];
                    w_size_n    = size_e'(bus.req_byte);
                    w_sext_n    = bus.req_sext;
                end
            end
            ACCESS: begin
                w_state_n     = r_we ? RESP : CAPTURE;
                w_rsp_valid_n = r_we;
                w_err_n       = 1'b0;
                w_rdata_n     = '0;
            end
            CAPTURE: begin
                w_state_n     = RESP;
                w_rsp_valid_n = 1'b1;
                w_err_n       = 1'b0;
                w_rdata_n     = w_rdata;
            end
            RESP: begin
                w_state_n     = bus.rsp_ready ? IDLE : RESP;
                w_rsp_valid_n = !bus.rsp_ready;
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_err     = r_err;
    assign bus.mem_cs      = r_cs;
    assign bus.mem_wen     = r_wen;
    assign bus.mem_address = r_address;
    assign bus.mem_d       = r_d;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
    import scs16_mem_pkg::*;

    typedef struct {
        int          lat;
        int          cs_cnt;
        logic [1:0]  wen;
        logic [10:0] addr;
        logic [15:0] d;
        logic [15:0] rdata;
        logic        err;
        bit          d_hi_bad;
        bit          bad;
        bit          nxt_rdy;
        time         acc_t;
    } obs_t;

    typedef struct {
        int          lat;
        int          cs_cnt;
        logic [1:0]  wen;
        logic [10:0] addr;
        logic [15:0] d;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] dm [0:2047] = '{default: 16'h0000};
    logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // dmem: registered read, byte-lane writes, junk in the unused upper bits
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_wen[0]) dm[bus.mem_address][7:0] <= bus.mem_d[7:0];
            if (bus.mem_wen[1]) dm[bus.mem_address][15:8] <= bus.mem_d[15:8];
            bus.mem_q <= {12'($urandom), dm[bus.mem_address]};
        end
    end

    // Reference: memory as a flat byte array, lane 0 = even byte address
    function automatic exp_t model(input logic we, input logic bt, input logic sx, input logic [11:0] a, input logic [15:0] wd);
        exp_t e;
        e.addr = a[11:1]; e.wen = 2'b00; e.d = 16'h0; e.rdata = 16'h0; e.err = 1'b0; e.cs_cnt = 1;
        if (!bt && a[0]) begin
            e.err = 1'b1; e.lat = 1; e.cs_cnt = 0;
        end else if (we) begin
            e.lat = 2;
            ref_mem[a] = wd[7:0];
            if (!bt) ref_mem[a + 12'd1] = wd[15:8];
            e.wen = !bt ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
            e.d = bt ? {wd[7:0], wd[7:0]} : wd;
        end else begin
            e.lat = 3;
            if (!bt) e.rdata = {ref_mem[a + 12'd1], ref_mem[a]};
            else if (sx) e.rdata = {{8{ref_mem[a][7]}}, ref_mem[a]};
            else e.rdata = {8'h00, ref_mem[a]};
        end
        return e;
    endfunction

    // Issues one request from a negedge, observes it, returns at the negedge after the handshake
    task automatic run_req(input logic we, input logic bt, input logic sx, input logic [11:0] a, input logic [15:0] wd, input int stall, output obs_t o);
        int n;
        o.lat = -1; o.cs_cnt = 0; o.wen = 2'b00; o.addr = '0; o.d = '0; o.rdata = '0; o.err = 1'b0;
        o.d_hi_bad = 1'b0; o.bad = 1'b0; o.nxt_rdy = 1'b0; o.acc_t = 0;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_byte = bt; bus.req_sext = sx;
        bus.req_addr = a; bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        o.acc_t = $time;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.req_valid = 1'b0;
            if (bus.mem_cs) begin
                o.cs_cnt++; o.wen = bus.mem_wen; o.addr = bus.mem_address; o.d = bus.mem_d[15:0];
                if (bus.mem_d[27:16] != 12'h0) o.d_hi_bad = 1'b1;
            end
            if (bus.mem_wen != 2'b00 && (!bus.mem_cs || !we)) o.bad = 1'b1;
            if (bus.req_ready) o.bad = 1'b1;
        end while (!bus.rsp_valid && n < 20);
        if (!bus.rsp_valid) return;
        o.lat = n; o.rdata = bus.rsp_rdata; o.err = bus.rsp_err;
        repeat (stall) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_rdata !== o.rdata || bus.rsp_err !== o.err || bus.req_ready || bus.mem_cs) o.bad = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        o.nxt_rdy = bus.req_ready && !bus.rsp_valid;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0/0/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
        checks++; if (bus.mem_cs !== 1'b0 || bus.mem_wen !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl got cs=%b wen=%b exp 0/00", bus.mem_cs, bus.mem_wen); end
        checks++; if (bus.mem_address !== 11'h0 || bus.mem_d !== 28'h0) begin errors++; $display("FAIL reset_mem_data got a=%h d=%h exp 0/0", bus.mem_address, bus.mem_d); end
        reset = 1'b0;
    endtask

    task automatic test_word();
        obs_t o; exp_t e;
        e = model(1'b1, 1'b0, 1'b0, 12'h010, 16'hBEEF);
        run_req(1'b1, 1'b0, 1'b0, 12'h010, 16'hBEEF, 0, o);
        checks++; if (o.cs_cnt !== 1 || o.wen !== 2'b11) begin errors++; $display("FAIL word_store_cs got cs=%0d wen=%b exp 1/11", o.cs_cnt, o.wen); end
        checks++; if (o.addr !== 11'h008 || o.d !== 16'hBEEF || o.d_hi_bad) begin errors++; $display("FAIL word_store_data got a=%h d=%h hi=%b exp 008/beef/0", o.addr, o.d, o.d_hi_bad); end
        checks++; if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== 16'h0) begin errors++; $display("FAIL word_store_rsp got lat=%0d e=%b d=%h exp 2/0/0000", o.lat, o.err, o.rdata); end
        e = model(1'b0, 1'b0, 1'b0, 12'h010, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h010, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'hBEEF || o.err !== 1'b0) begin errors++; $display("FAIL word_load_data got d=%h e=%b exp beef/0", o.rdata, o.err); end
        checks++; if (o.lat !== 3 || o.cs_cnt !== 1 || o.bad || !o.nxt_rdy) begin errors++; $display("FAIL word_load_timing got lat=%0d cs=%0d bad=%b nr=%b exp 3/1/0/1", o.lat, o.cs_cnt, o.bad, o.nxt_rdy); end
    endtask

    task automatic test_byte_store();
        obs_t o; exp_t e;
        e = model(1'b1, 1'b0, 1'b0, 12'h020, 16'h0000);
        run_req(1'b1, 1'b0, 1'b0, 12'h020, 16'h0000, 0, o);
        e = model(1'b1, 1'b1, 1'b0, 12'h021, 16'hAB12);
        run_req(1'b1, 1'b1, 1'b0, 12'h021, 16'hAB12, 0, o);
        checks++; if (o.wen !== 2'b10 || o.d !== 16'h1212 || o.addr !== 11'h010) begin errors++; $display("FAIL byte_store_hi got wen=%b d=%h a=%h exp 10/1212/010", o.wen, o.d, o.addr); end
        e = model(1'b1, 1'b1, 1'b0, 12'h020, 16'hCD34);
        run_req(1'b1, 1'b1, 1'b0, 12'h020, 16'hCD34, 0, o);
        checks++; if (o.wen !== 2'b01 || o.d !== 16'h3434) begin errors++; $display("FAIL byte_store_lo got wen=%b d=%h exp 01/3434", o.wen, o.d); end
        e = model(1'b0, 1'b0, 1'b0, 12'h020, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h020, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'h1234) begin errors++; $display("FAIL byte_store_merge got %h exp 1234", o.rdata); end
    endtask

    task automatic test_sext();
        obs_t o; exp_t e;
        e = model(1'b1, 1'b0, 1'b0, 12'h040, 16'h80FF);
        run_req(1'b1, 1'b0, 1'b0, 12'h040, 16'h80FF, 0, o);
        e = model(1'b0, 1'b1, 1'b1, 12'h041, 16'h0);
        run_req(1'b0, 1'b1, 1'b1, 12'h041, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'hFF80 || o.wen !== 2'b00) begin errors++; $display("FAIL sext_hi got d=%h wen=%b exp ff80/00", o.rdata, o.wen); end
        e = model(1'b0, 1'b1, 1'b0, 12'h040, 16'h0);
        run_req(1'b0, 1'b1, 1'b0, 12'h040, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'h00FF) begin errors++; $display("FAIL zext_lo got %h exp 00ff", o.rdata); end
        e = model(1'b0, 1'b1, 1'b0, 12'h041, 16'h0);
        run_req(1'b0, 1'b1, 1'b0, 12'h041, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'h0080) begin errors++; $display("FAIL zext_hi got %h exp 0080", o.rdata); end
        e = model(1'b1, 1'b1, 1'b0, 12'hFFF, 16'h00A5);
        run_req(1'b1, 1'b1, 1'b0, 12'hFFF, 16'h00A5, 0, o);
        checks++; if (o.addr !== 11'h7FF || o.wen !== 2'b10) begin errors++; $display("FAIL wrap_store got a=%h wen=%b exp 7ff/10", o.addr, o.wen); end
        e = model(1'b0, 1'b1, 1'b1, 12'hFFF, 16'h0);
        run_req(1'b0, 1'b1, 1'b1, 12'hFFF, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'hFFA5) begin errors++; $display("FAIL wrap_load got %h exp ffa5", o.rdata); end
    endtask

    task automatic test_misaligned();
        obs_t o; exp_t e;
        e = model(1'b0, 1'b0, 1'b0, 12'h033, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h033, 16'h0, 0, o);
        checks++; if (o.cs_cnt !== 0 || o.err !== 1'b1 || o.rdata !== 16'h0) begin errors++; $display("FAIL misaligned_rsp got cs=%0d e=%b d=%h exp 0/1/0000", o.cs_cnt, o.err, o.rdata); end
        checks++; if (o.lat !== 1 || !o.nxt_rdy) begin errors++; $display("FAIL misaligned_lat got lat=%0d nr=%b exp 1/1", o.lat, o.nxt_rdy); end
        e = model(1'b0, 1'b0, 1'b0, 12'h010, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h010, 16'h0, 0, o);
        checks++; if (o.rdata !== 16'hBEEF || o.err !== 1'b0) begin errors++; $display("FAIL after_misaligned got d=%h e=%b exp beef/0", o.rdata, o.err); end
    endtask

    task automatic test_stall();
        obs_t o; exp_t e;
        e = model(1'b0, 1'b0, 1'b0, 12'h020, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h020, 16'h0, 4, o);
        checks++; if (o.rdata !== 16'h1234 || o.lat !== 3) begin errors++; $display("FAIL stall_data got d=%h lat=%0d exp 1234/3", o.rdata, o.lat); end
        checks++; if (o.bad || !o.nxt_rdy) begin errors++; $display("FAIL stall_hold got bad=%b nr=%b exp 0/1", o.bad, o.nxt_rdy); end
    endtask

    task automatic test_reset_abort();
        obs_t o; exp_t e;
        bit seen;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_byte = 1'b0; bus.req_sext = 1'b0;
        bus.req_addr = 12'h050; bus.req_wdata = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_cs !== 1'b1) begin errors++; $display("FAIL abort_access_cs got %b exp 1", bus.mem_cs); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.mem_cs !== 1'b0 || bus.mem_wen !== 2'b00 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_access got cs=%b wen=%b rdy=%b exp 0/00/1", bus.mem_cs, bus.mem_wen, bus.req_ready); end
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h010;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.mem_cs !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_capture got cs=%b v=%b rdy=%b exp 0/0/1", bus.mem_cs, bus.rsp_valid, bus.req_ready); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_rsp got rsp_valid=1 exp 0"); end
        e = model(1'b0, 1'b0, 1'b0, 12'h050, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h050, 16'h0, 0, o);
        checks++; if (o.rdata !== e.rdata || o.lat !== 3) begin errors++; $display("FAIL abort_store_dropped got d=%h lat=%0d exp %h/3", o.rdata, o.lat, e.rdata); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2; exp_t e;
        e = model(1'b1, 1'b0, 1'b0, 12'h060, 16'h1111);
        run_req(1'b1, 1'b0, 1'b0, 12'h060, 16'h1111, 0, o1);
        e = model(1'b1, 1'b0, 1'b0, 12'h062, 16'h2222);
        run_req(1'b1, 1'b0, 1'b0, 12'h062, 16'h2222, 0, o2);
        checks++; if (o2.acc_t - o1.acc_t !== 30) begin errors++; $display("FAIL b2b_store got %0t exp 30", o2.acc_t - o1.acc_t); end
        e = model(1'b0, 1'b0, 1'b0, 12'h060, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h060, 16'h0, 0, o1);
        e = model(1'b0, 1'b0, 1'b0, 12'h062, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h062, 16'h0, 0, o2);
        checks++; if (o2.acc_t - o1.acc_t !== 40 || o2.rdata !== 16'h2222) begin errors++; $display("FAIL b2b_load got dt=%0t d=%h exp 40/2222", o2.acc_t - o1.acc_t, o2.rdata); end
        e = model(1'b0, 1'b0, 1'b0, 12'h061, 16'h0);
        run_req(1'b0, 1'b0, 1'b0, 12'h061, 16'h0, 0, o1);
        e = model(1'b1, 1'b0, 1'b0, 12'h063, 16'h0);
        run_req(1'b1, 1'b0, 1'b0, 12'h063, 16'h0, 0, o2);
        checks++; if (o2.acc_t - o1.acc_t !== 20 || o2.err !== 1'b1) begin errors++; $display("FAIL b2b_err got dt=%0t e=%b exp 20/1", o2.acc_t - o1.acc_t, o2.err); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic we, bt, sx;
        logic [11:0] a;
        logic [15:0] wd;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            bt = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4080, 4095)) : 12'($urandom_range(0, 63));
            wd = 16'($urandom);
            e = model(we, bt, sx, a, wd);
            run_req(we, bt, sx, a, wd, $urandom_range(0, 2), o);
            checks++; if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin errors++; $display("FAIL rand_rsp #%0d we=%b b=%b a=%h got lat=%0d e=%b d=%h exp %0d/%b/%h", i, we, bt, a, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata); end
            checks++; if (o.cs_cnt !== e.cs_cnt || (e.cs_cnt == 1 && (o.wen !== e.wen || o.addr !== e.addr || (we && o.d !== e.d)))) begin errors++; $display("FAIL rand_mem #%0d got cs=%0d wen=%b a=%h d=%h exp %0d/%b/%h/%h", i, o.cs_cnt, o.wen, o.addr, o.d, e.cs_cnt, e.wen, e.addr, e.d); end
            checks++; if (o.bad || o.d_hi_bad || !o.nxt_rdy) begin errors++; $display("FAIL rand_proto #%0d got bad=%b hi=%b nr=%b exp 0/0/1", i, o.bad, o.d_hi_bad, o.nxt_rdy); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0; bus.req_sext = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte_store();
        test_sext();
        test_misaligned();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator that drives the dmem data-memory port (cs, wen[1:0], address, d, q) on behalf of the scs16 core.
- Accepts byte-addressed 16-bit load/store requests over a valid/ready handshake.
- Converts each request to word address + byte-lane write enables.
- Captures the registered read data and returns it, lane-aligned and extended, over a valid/ready response channel.
- Sits between the core execute stage and dmem.

Parameters:
WIDTH, 28, dmem word width; only bits [15:0] carry data.
ADD_SIZE, 11, dmem word-address width.
ADDR_W, 12, core byte-address width (ADD_SIZE+1).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_byte  in  1  1=byte access, 0=16-bit word access
req_sext  in  1  sign-extend byte load (ignored otherwise)
req_addr  in  ADDR_W  byte address; bit0 selects lane
req_wdata  in  16  store data (byte store uses [7:0])
rsp_valid  out  1  response valid, one per accepted request
rsp_ready  in  1  response consumed when valid&&ready
rsp_rdata  out  16  load data; 0 for stores and errors
rsp_err  out  1  misaligned word access
mem_cs  out  1  dmem chip select
mem_wen  out  2  dmem byte write enables ([1]=bits 15:8, [0]=bits 7:0)
mem_address  out  ADD_SIZE  dmem word address = req_addr[ADDR_W-1:1]
mem_d  out  WIDTH  dmem write data, bits [WIDTH-1:16]=0
mem_q  in  WIDTH  dmem registered read data, bits above 15 ignored

Behaviour:
- Reset (async): state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_cs=0, mem_wen=0, mem_address=0, mem_d=0.
- All mem_* outputs are registered. mem_cs/mem_wen are high for exactly one cycle per memory access and 0 otherwise. A load never has mem_wen!=0.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On accept:
  - Legal access: latch request, drive mem_* -> ACCESS.
  - Misaligned word (req_byte=0, req_addr[0]=1): no memory access; rsp_err=1, rsp_rdata=0 -> RESP.
- ACCESS: mem_cs=1 for this cycle; dmem acts at the end-of-cycle edge.
  - Store -> RESP with rsp_err=0, rsp_rdata=0.
  - Load -> CAPTURE.
- CAPTURE: mem_cs=0. Sample mem_q[15:0], align/extend into rsp_rdata -> RESP.
- RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready. On handshake -> IDLE. req_ready=0 in every state except IDLE.
- Latency from accept edge to rsp_valid: store 2 cycles, load 3 cycles, error 1 cycle. Throughput: one request per latency+1 cycles when rsp_ready=1.
- Lane rules:
  - Word store: wen=11, d[15:0]=wdata.
  - Byte store: addr[0]=0 -> wen=01; addr[0]=1 -> wen=10. d[15:0]={wdata[7:0],wdata[7:0]} in both cases.
  - Byte load: lane = q[7:0] if addr[0]=0, else q[15:8]. Zero-extend, or sign-extend from bit 7 when req_sext=1.
  - Word load: q[15:0].
- Address wrap: the top byte address maps to the last word; no overflow checks.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_cs/mem_wen drop asynchronously. A pending response is discarded and not replayed. dmem contents after reset are defined by dmem's own reset.
- req_valid while req_ready=0: ignored; the requester must hold the request.

Decomposition:
- Package scs16_mem_pkg:
  - state enum (IDLE/ACCESS/CAPTURE/RESP)
  - WEN_NONE=2'b00, WEN_LO=2'b01, WEN_HI=2'b10, WEN_WORD=2'b11
  - SIZE_BYTE/SIZE_WORD encoding
  - default WIDTH/ADD_SIZE constants shared with dmem
- One sub-module: dmem_lane_align. It is combinational and contains both the store steering (addr bit0, size, wdata -> wen, d) and the load extraction/extension (addr bit0, size, sext, q -> rdata). It is reused by a future instruction-fetch port.

Test Plan:
- Word store 0xBEEF @0x010, then word load @0x010 -> mem_cs/wen=11 one cycle, mem_address=0x008, mem_d=0x000BEEF. Load rsp_rdata=0xBEEF, rsp_err=0, rsp_valid 3 cycles after accept.
- Byte stores 0x12 @0x021 and 0x34 @0x020 into a cleared word, then word load @0x020 -> wen=10 then 01, mem_d[15:0]=0x1212/0x3434, rsp_rdata=0x1234.
- Word 0x80FF at @0x040; byte load @0x041 sext=1 -> 0xFF80. Byte load @0x040 sext=0 -> 0x00FF. Byte load @0x041 sext=0 -> 0x0080.
- Word load @0x033 (misaligned) -> mem_cs never asserted, rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept. A following legal load succeeds.
- rsp_ready=0 for 4 cycles on a load response -> rsp_valid/rsp_rdata stable, req_ready=0 throughout. The next request is accepted the cycle after the handshake.
- Assert reset in CAPTURE -> mem_cs=0, rsp_valid=0, req_ready=1 immediately. No response for the aborted load. The next request behaves normally.
